// File: rtl/decoder_seq_if.sv
// Request/decode bus for decoder_seq: 3-bit code request, mask/scan controls and
// the eight one-hot decoded lines with handshake status.
interface decoder_seq_if;
    logic A0;
    logic A1;
    logic A2;
    logic valid;
    logic ready;
    logic EN;
    logic SCAN;
    logic D0;
    logic D1;
    logic D2;
    logic D3;
    logic D4;
    logic D5;
    logic D6;
    logic D7;
    logic busy;

    modport master (
        output A0, A1, A2, valid, EN, SCAN,
        input  ready, busy, D0, D1, D2, D3, D4, D5, D6, D7
    );

    modport slave (
        input  A0, A1, A2, valid, EN, SCAN,
        output ready, busy, D0, D1, D2, D3, D4, D5, D6, D7
    );
endinterface

// File: rtl/decoder_seq.sv
// Registered 3-to-8 one-hot decoder with per-request pulse stretching and an
// auto-scan mode that walks D0..D7 in fixed-width slots.
module decoder_seq #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    decoder_seq_if.slave  dec_io
);

    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned OUT_W  = 8;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q,  code_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [CODE_W-1:0]   idx_q,   idx_d;
    logic [OUT_W-1:0]    d_q,     d_d;

    logic [CODE_W-1:0]   code_in;
    logic [CODE_W-1:0]   idx_next;
    logic                accept;
    logic                ready_int;

    function automatic logic [OUT_W-1:0] one_hot(input logic [CODE_W-1:0] c);
        one_hot = OUT_W'(1) << c;
    endfunction

    // EN only gates what is shown; sequencing ignores it.
    function automatic logic [OUT_W-1:0] masked(input logic en, input logic [OUT_W-1:0] v);
        masked = en ? v : '0;
    endfunction

    assign code_in   = {dec_io.A2, dec_io.A1, dec_io.A0};
    assign idx_next  = idx_q + CODE_W'(1);
    assign ready_int = (state_q == ST_IDLE);
    assign accept    = dec_io.valid & ready_int;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        d_d     = d_q;

        unique case (state_q)
            ST_IDLE: begin
                d_d = '0;
                if (accept) begin
                    code_d  = code_in;
                    d_d     = masked(dec_io.EN, one_hot(code_in));
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_HOLD;
                end else if (dec_io.SCAN) begin
                    idx_d   = '0;
                    d_d     = masked(dec_io.EN, one_hot('0));
                    cnt_d   = CNT_RELOAD;
                    state_d = ST_SCAN;
                end
            end

            ST_HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    d_d   = masked(dec_io.EN, one_hot(code_q));
                end else begin
                    d_d     = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_SCAN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    d_d   = masked(dec_io.EN, one_hot(idx_q));
                end else if (dec_io.SCAN) begin
                    // Slot end with scan still requested: advance and reload, no gap.
                    idx_d = idx_next;
                    d_d   = masked(dec_io.EN, one_hot(idx_next));
                    cnt_d = CNT_RELOAD;
                end else begin
                    idx_d   = '0;
                    d_d     = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                d_d     = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dec_io.ready = ready_int;
    assign dec_io.busy  = ~ready_int;
    assign dec_io.D0    = d_q[0];
    assign dec_io.D1    = d_q[1];
    assign dec_io.D2    = d_q[2];
    assign dec_io.D3    = d_q[3];
    assign dec_io.D4    = d_q[4];
    assign dec_io.D5    = d_q[5];
    assign dec_io.D6    = d_q[6];
    assign dec_io.D7    = d_q[7];

endmodule
